// File: rtl/ex_sequencer.sv
// rtl/ex_sequencer.sv - EX-stage instruction sequencer (IDLE/LOAD/EXEC/STORE/BRANCH)
//
// Ports:
//   clock        in   system clock, rising-edge active
//   reset        in   asynchronous active-low reset
//   issue_valid  in   decoded instruction offered by ID
//   ctrl[7:0]    in   bit0 WR, 1 WM, 2 RM, 3 NEQ, 4 J, 5 JC, 6 SIN, 7 INA
//   zero_flag    in   registered zero result of the EX stage
//   jump_target  in   PC + sign-extended offset from the jump adder
//   issue_ready  out  new instruction can be accepted (IDLE)
//   ac_accept    out  load enable for the ALU input accumulator (LOAD)
//   sout         out  load enable for ALU output accumulator / zero register (STORE)
//   mem_valid    out  one-cycle pulse handing mem_ctrl to MEM
//   mem_ctrl     out  latched ctrl[5:0], driven while mem_valid is high
//   pc_load      out  PC redirect
//   flush        out  flush of younger stages
//   pc_next      out  redirect address, 0 whenever pc_load is 0
//   busy         out  sequencer not in IDLE
//   retire_cnt   out  count of completed instructions, wraps at 256
//
// Optional feature: EX_JUMP_FAST_EN - an unconditional jump accepted in IDLE
// redirects and retires in the acceptance cycle instead of visiting BRANCH.

module ex_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [7:0] ctrl,
    input  logic       zero_flag,
    input  logic [7:0] jump_target,
    output logic       issue_ready,
    output logic       ac_accept,
    output logic       sout,
    output logic       mem_valid,
    output logic [5:0] mem_ctrl,
    output logic       pc_load,
    output logic       flush,
    output logic [7:0] pc_next,
    output logic       busy,
    output logic [7:0] retire_cnt
);

    localparam int NEQ = 3;
    localparam int J   = 4;
    localparam int JC  = 5;
    localparam int SIN = 6;
    localparam int INA = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        EXEC   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4
    } seqState_t;

    seqState_t  state;
    seqState_t  stateNext;
    // SIN/INA only steer the IDLE decision, so only the bits needed after
    // acceptance are kept.
    logic [5:0] ctrlQ;
    logic [7:0] retireQ;
    logic       accept;
    logic       retire;
    logic       taken;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ctrlQ   <= 6'd0;
            retireQ <= 8'd0;
        end else begin
            state <= stateNext;
            if (accept) begin
                ctrlQ <= ctrl[5:0];
            end
            if (retire) begin
                retireQ <= retireQ + 8'd1;
            end
        end
    end

    always_comb begin
        stateNext   = state;
        accept      = 1'b0;
        retire      = 1'b0;
        issue_ready = 1'b0;
        ac_accept   = 1'b0;
        sout        = 1'b0;
        mem_valid   = 1'b0;
        mem_ctrl    = 6'd0;
        pc_load     = 1'b0;
        flush       = 1'b0;
        pc_next     = 8'd0;
        taken       = ctrlQ[J] | (ctrlQ[JC] & (zero_flag != ctrlQ[NEQ]));

        case (state)
            IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    accept = 1'b1;
`ifdef EX_JUMP_FAST_EN
                    if (ctrl[J]) begin
                        // Redirect straight from IDLE; this is a Mealy path
                        // on the incoming ctrl, not on ctrlQ.
                        mem_valid = 1'b1;
                        mem_ctrl  = ctrl[5:0];
                        pc_load   = 1'b1;
                        flush     = 1'b1;
                        pc_next   = jump_target;
                        retire    = 1'b1;
                        stateNext = IDLE;
                    end else if (ctrl[SIN] | ctrl[INA]) begin
                        stateNext = LOAD;
                    end else begin
                        stateNext = EXEC;
                    end
`else
                    if (ctrl[J]) begin
                        stateNext = BRANCH;
                    end else if (ctrl[SIN] | ctrl[INA]) begin
                        stateNext = LOAD;
                    end else begin
                        stateNext = EXEC;
                    end
`endif
                end
            end
            LOAD: begin
                ac_accept = 1'b1;
                stateNext = EXEC;
            end
            EXEC: begin
                stateNext = STORE;
            end
            STORE: begin
                sout      = 1'b1;
                mem_valid = 1'b1;
                mem_ctrl  = ctrlQ;
                stateNext = ctrlQ[JC] ? BRANCH : IDLE;
            end
            BRANCH: begin
                if (taken) begin
                    pc_load = 1'b1;
                    flush   = 1'b1;
                    pc_next = jump_target;
                end
                // J skipped STORE, so its MEM handoff happens here.
                if (ctrlQ[J]) begin
                    mem_valid = 1'b1;
                    mem_ctrl  = ctrlQ;
                end
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (state != IDLE && stateNext == IDLE) begin
            retire = 1'b1;
        end

        // Outputs must drop the moment reset asserts, not at the next edge.
        if (!reset) begin
            accept      = 1'b0;
            retire      = 1'b0;
            issue_ready = 1'b0;
            ac_accept   = 1'b0;
            sout        = 1'b0;
            mem_valid   = 1'b0;
            mem_ctrl    = 6'd0;
            pc_load     = 1'b0;
            flush       = 1'b0;
            pc_next     = 8'd0;
        end
    end

    assign busy       = (state != IDLE);
    assign retire_cnt = retireQ;

endmodule
